// File: rtl/pe_pkg.sv
// Shared types and helpers for the sequential priority scanner.
//   state_e   : scanner FSM states
//   idx_width : index width for a given request-vector width
package pe_pkg;

    localparam int unsigned PE_MIN_WIDTH = 2;
    localparam int unsigned PE_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_ZERO = 2'd2
    } state_e;

    // Index width; never below one bit so a 2-wide vector still has an index.
    function automatic int unsigned idx_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/pe_scan_if.sv
// Request/response bus of the priority scanner.
//   in_valid/in_ready/i           : request vector handshake
//   out_valid/out_ready/y/last/none : per-index response handshake
//   master : request source + consumer side
//   slave  : scanner side
interface pe_scan_if
    import pe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = idx_width(WIDTH)
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] i;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  y;
    logic             last;
    logic             none;

    modport master (
        output in_valid,
        output i,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y,
        input  last,
        input  none
    );

    modport slave (
        input  in_valid,
        input  i,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y,
        output last,
        output none
    );

endinterface

// File: rtl/pe_prio_comb.sv
// Combinational priority encoder.
//   vec_i   : vector to encode
//   idx_o   : highest (MSB_FIRST=1) or lowest (MSB_FIRST=0) set index, 0 if none
//   found_o : vec_i has at least one bit set
module pe_prio_comb
    import pe_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned IDXW      = idx_width(WIDTH),
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDXW-1:0]  idx_o,
    output logic             found_o
);

    // The loop walks toward the priority end so the last hit wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        if (MSB_FIRST) begin
            for (int k = 0; k < int'(WIDTH); k++) begin
                if (vec_i[k]) begin
                    idx_o   = IDXW'(k);
                    found_o = 1'b1;
                end
            end
        end else begin
            for (int k = int'(WIDTH) - 1; k >= 0; k--) begin
                if (vec_i[k]) begin
                    idx_o   = IDXW'(k);
                    found_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pe_scan.sv
// Sequential priority scanner: captures a request vector and emits the index
// of every set bit, one per output handshake, in priority order.
//   clk, rst_n : clock, async active-low reset
//   en         : global enable; 0 freezes state and blocks both handshakes
//   bus        : pe_scan_if slave (request in, index out)
module pe_scan
    import pe_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned IDXW      = idx_width(WIDTH),
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    pe_scan_if.slave    bus
);

    state_e           state_q;
    logic [WIDTH-1:0] pending_q;

    logic [IDXW-1:0]  prio_idx;
    logic             prio_found;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] pending_rest;

    logic             in_ready_c;
    logic             out_valid_c;
    logic             in_fire;
    logic             out_fire;

    // Current priority index of the captured copy.
    pe_prio_comb #(
        .WIDTH     (WIDTH),
        .IDXW      (IDXW),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio (
        .vec_i   (pending_q),
        .idx_o   (prio_idx),
        .found_o (prio_found)
    );

    // One-hot mask of the bit being emitted, and what remains once it is served.
    always_comb begin
        clr_mask = '0;
        for (int k = 0; k < int'(WIDTH); k++) begin
            clr_mask[k] = (IDXW'(k) == prio_idx);
        end
        pending_rest = pending_q & ~clr_mask;
    end

    // rst_n gates in_ready so nothing is offered while reset is held.
    assign in_ready_c  = rst_n & en & (state_q == ST_IDLE);
    assign out_valid_c = en & (state_q != ST_IDLE);
    assign in_fire     = bus.in_valid & in_ready_c;
    assign out_fire    = out_valid_c & bus.out_ready;

    // Scanner FSM and captured vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_fire) begin
                        pending_q <= bus.i;
                        state_q   <= (bus.i != '0) ? ST_SCAN : ST_ZERO;
                    end
                end
                ST_SCAN: begin
                    if (out_fire) begin
                        pending_q <= pending_rest;
                        if (pending_rest == '0) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_ZERO: begin
                    if (out_fire) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    pending_q <= '0;
                end
            endcase
        end
    end

    // Outputs depend only on state/pending (and en); all zero when not valid.
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.y         = (out_valid_c && state_q == ST_SCAN) ? prio_idx : '0;
    assign bus.last      = out_valid_c &
                           ((state_q == ST_SCAN) ? (prio_found && pending_rest == '0) : 1'b1);
    assign bus.none      = out_valid_c & (state_q == ST_ZERO);

endmodule

// File: doc/pe_scan.md
Name: pe_scan

Overview:
- Parametrised, sequential successor to the 8-bit priority encoder.
- Captures a WIDTH-bit request vector and emits the index of every set bit, one per output handshake, in priority order. Highest index first by default; lowest first is a parameter option.
- Sits between request sources (interrupt/flag vectors) and a consumer that services one index at a time.
- Keeps the enable input. Stalls instead of tristating, because an internal bus cannot carry Z.

Parameters:
- WIDTH, 8, request vector width; legal range 2..64.
- IDXW, $clog2(WIDTH), index width (derived; do not override).
- MSB_FIRST, 1, 1 = highest set index has priority; 0 = lowest set index has priority.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; 0 freezes all state and blocks both handshakes.
- in_valid  input  1  request vector valid.
- in_ready  output  1  block can accept a vector.
- i  input  WIDTH  request vector.
- out_valid  output  1  y/last/none valid.
- out_ready  input  1  consumer accepts current output.
- y  output  IDXW  index of current highest-priority pending bit.
- last  output  1  current output is the final one for this vector.
- none  output  1  captured vector was all-zero (y=0 in that case).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pending=0.
  - out_valid=0, y=0, last=0, none=0.
  - in_ready=0 while rst_n=0.
- Output rules:
  - y, last and none are derived only from registered state and pending; no combinational path from i to y.
  - When out_valid=0, y=0, last=0, none=0.
- en=0: no register changes, in_ready=0, out_valid=0. Pending state is retained and resumes when en returns to 1.
- States:
  - IDLE: in_ready=en. On in_valid&in_ready: pending<=i. Next state is SCAN if i!=0, ZERO if i==0.
  - SCAN:
    - out_valid=en.
    - y = highest set index of pending (MSB_FIRST=1) or lowest set index (MSB_FIRST=0).
    - last = (pending has exactly one bit set).
    - none=0.
    - On out_valid&out_ready: clear bit y in pending. If last, go to IDLE; otherwise stay in SCAN.
  - ZERO:
    - out_valid=en, y=0, last=1, none=1.
    - On out_valid&out_ready: go to IDLE.
- Latency:
  - Vector accepted at edge N; first out_valid is high during cycle N+1.
  - Each subsequent index follows one cycle after the previous handshake.
  - A vector with k set bits needs k output handshakes, plus one IDLE cycle, before the next vector is accepted.
- Backpressure: out_ready=0 holds y/last/none stable; pending does not change.
- in_ready=0 in SCAN and ZERO. A new vector is never accepted mid-scan; changes on i during the scan are ignored.
- Reset mid-scan discards pending immediately; out_valid drops asynchronously.
- Bits are scanned from the captured copy only, so order is deterministic regardless of later input changes.
- WIDTH not a power of two: indices range 0..WIDTH-1 only.

Decomposition:
- Shared package pe_pkg:
  - state typedef (IDLE, SCAN, ZERO).
  - function for index width.
- One natural sub-module: pe_prio_comb.
  - Combinational, parametrised WIDTH/IDXW/MSB_FIRST.
  - Returns index and found flag for a vector; implemented as a loop, not a hand-unrolled if-chain.
  - Reused for y and for the one-hot clear mask.
- last is computed as "pending with bit y cleared == 0" in the top level.

Test Plan:
- Reset then single bit: WIDTH=8, i=8'b0010_0000 accepted, out_ready=1 -> next cycle out_valid=1, y=5, last=1, none=0. Following cycle in_ready=1.
- Multi-bit MSB_FIRST=1: i=8'b1000_0110, out_ready=1 -> y sequence 7,2,1 on three consecutive cycles; last=1 only with y=1.
- Zero vector: i=0 accepted -> one output with y=0, none=1, last=1; then IDLE.
- Backpressure and enable:
  - i=8'b0101_0000; hold out_ready=0 for 3 cycles -> y=6 stable, no advance.
  - Then en=0 for 2 cycles -> out_valid=0 and state frozen.
  - Then en=1, out_ready=1 -> y=6, then y=4 with last=1.
- MSB_FIRST=0, WIDTH=16: i=16'h8001 -> y=0, then y=15 with last=1.
- Reset mid-scan: i=8'hFF, after two handshakes (y=7,6) assert rst_n=0 asynchronously -> out_valid=0 immediately. After release, in_ready=1 and no stale index is emitted.
